// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants for the sequential binary-to-BCD converter.
// Provides default widths, double-dabble adjust constants, FSM encodings and
// a helper that returns the largest value representable in a given digit count.
package bin_to_bcd_seq_pkg;

    localparam int unsigned DEF_BIN_W   = 14;
    localparam int unsigned DEF_DIGITS  = 4;
    localparam int unsigned BCD_DIGIT_W = 4;

    localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESH = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0] ADJ_ADD    = 4'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_OVF   = 2'd2;

    localparam logic [13:0] MAX_VAL_4DIG = 14'd9999;

    // Largest value that fits in 'digits' BCD digits (10^digits - 1).
    function automatic int unsigned bcd_max_val(input int unsigned digits);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            r = r * 10;
        end
        return r - 1;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle for bin_to_bcd_seq.
//   start, bin                   : requester -> converter
//   busy, done, bcd, overflow    : converter -> requester
// master = requester side, slave = converter side.
interface bin_to_bcd_seq_if
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int unsigned BIN_W  = DEF_BIN_W,
    parameter int unsigned DIGITS = DEF_DIGITS
);
    logic                            start;
    logic [BIN_W-1:0]                bin;
    logic                            busy;
    logic                            done;
    logic [BCD_DIGIT_W*DIGITS-1:0]   bcd;
    logic                            overflow;

    modport master (
        output start, bin,
        input  busy, done, bcd, overflow
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, overflow
    );
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit adjust: adds 3 to a BCD digit that is 5 or more.
//   din    : current BCD digit (never above 9 in normal operation)
//   dout_c : adjusted digit, combinational, 4-bit wrap
module bcd_digit_adj
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout_c
);
    always_comb begin
        dout_c = din;
        if (din >= ADJ_THRESH) begin
            dout_c = din + ADJ_ADD;
        end
    end
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: binary in, packed BCD out, one
// adjust+shift step per clock with a start/done handshake.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : slave side of bin_to_bcd_seq_if
//              start/bin in; busy, done (1-cycle pulse), bcd, overflow out
// Out-of-range requests skip the shifter and report overflow after one cycle.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int unsigned BIN_W  = DEF_BIN_W,
    parameter int unsigned DIGITS = DEF_DIGITS
)
(
    input  logic            clk,
    input  logic            rst,
    bin_to_bcd_seq_if.slave bus
);
    localparam int unsigned BCD_W   = BCD_DIGIT_W * DIGITS;
    localparam int unsigned SR_W    = BCD_W + BIN_W;
    localparam int unsigned CNT_W   = $clog2(BIN_W + 1);
    localparam int unsigned MAX_VAL = bcd_max_val(DIGITS);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SR_W-1:0]  sreg_q, sreg_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;

    logic [BCD_W-1:0] adj_field;
    logic [SR_W-1:0]  shifted;

    // Per-digit adjust of the BCD field of the shift register.
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .din    (sreg_q[BIN_W + BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .dout_c (adj_field[BCD_DIGIT_W*i +: BCD_DIGIT_W])
        );
    end

    // Adjusted BCD field rejoined with the binary tail, then shifted left.
    assign shifted = {adj_field, sreg_q[BIN_W-1:0]} << 1;

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (32'(bus.bin) > MAX_VAL) begin
                        state_d = ST_OVF;
                    end else begin
                        sreg_d  = SR_W'(bus.bin);
                        cnt_d   = CNT_W'(BIN_W);
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                sreg_d = shifted;
                cnt_d  = cnt_q - CNT_W'(1);
                // Final step: result is taken straight from the shifted value.
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = shifted[SR_W-1 -: BCD_W];
                    ovf_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_OVF: begin
                bcd_d   = '0;
                ovf_d   = 1'b1;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sreg_q  <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd      = bcd_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: a stimulus process issues requests,
// an acceptance model pushes the expected result, and a monitor pops and
// compares on every done pulse.
module tb_bin_to_bcd_seq;
    import bin_to_bcd_seq_pkg::*;

    localparam int unsigned BIN_W  = 14;
    localparam int unsigned DIGITS = 4;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int unsigned acc;
        int unsigned lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus();

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    int unsigned cyc      = 0;
    int unsigned mdl_cnt  = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_done   = 0;
    logic        prev_done = 1'b0;
    logic        hand_valid = 1'b0;
    logic [15:0] hand_bcd   = 16'h0;
    logic        hand_ovf   = 1'b0;

    // Arithmetic reference (division based, independent of double dabble).
    function automatic logic [15:0] ref_bcd(input int unsigned v);
        logic [15:0] r;
        r = 16'h0;
        if (v <= 9999) begin
            r[3:0]   = 4'(v % 10);
            r[7:4]   = 4'((v / 10) % 10);
            r[11:8]  = 4'((v / 100) % 10);
            r[15:12] = 4'((v / 1000) % 10);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Acceptance model: tracks when the converter can take a request.
    always @(posedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        if (rst) begin
            mdl_cnt = 0;
            exp_q.delete();
        end else if (mdl_cnt == 0) begin
            if (bus.start) begin
                e.acc = cyc;
                e.lat = (bus.bin > 14'd9999) ? 1 : BIN_W;
                e.bcd = hand_valid ? hand_bcd : ref_bcd(32'(bus.bin));
                e.ovf = hand_valid ? hand_ovf : (bus.bin > 14'd9999);
                exp_q.push_back(e);
                mdl_cnt = e.lat;
            end
        end else begin
            mdl_cnt = mdl_cnt - 1;
        end
    end

    // Monitor: busy timing, done width, result compare.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("busy", 32'(bus.busy), 32'(mdl_cnt != 0));
            if (prev_done) begin
                check("done_width", 32'(bus.done), 32'(0));
            end
            if (bus.done) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no result (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("bcd", 32'(bus.bcd), 32'(e.bcd));
                    check("overflow", 32'(bus.overflow), 32'(e.ovf));
                    check("latency", cyc - e.acc, e.lat);
                end
            end
            prev_done = bus.done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // Issue one request at the next free edge; caller sits on a negedge.
    task automatic convert(input logic [13:0] v, input logic hv, input logic [15:0] hb, input logic ho);
        int t;
        t = 0;
        while (mdl_cnt != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: got busy after %0d cycles expected idle", t);
        end
        bus.bin    = v;
        bus.start  = 1'b1;
        hand_valid = hv;
        hand_bcd   = hb;
        hand_ovf   = ho;
        @(negedge clk);
        bus.start  = 1'b0;
        hand_valid = 1'b0;
        bus.bin    = ~v;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((mdl_cnt != 0 || exp_q.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        bus.start = 1'b0;
        bus.bin   = '0;
        #1 rst = 1'b1;
        #2;
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_done", 32'(bus.done), 32'(0));
        check("rst_bcd", 32'(bus.bcd), 32'(0));
        check("rst_ovf", 32'(bus.overflow), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors with hand-computed results.
        convert(14'd0,     1'b1, 16'h0000, 1'b0);
        convert(14'd1331,  1'b1, 16'h1331, 1'b0);
        convert(14'd1332,  1'b1, 16'h1332, 1'b0);
        convert(14'd9999,  1'b1, 16'h9999, 1'b0);
        convert(14'd10000, 1'b1, 16'h0000, 1'b1);
        convert(14'd16383, 1'b1, 16'h0000, 1'b1);
        convert(14'd5,     1'b1, 16'h0005, 1'b0);
        convert(14'd1000,  1'b1, 16'h1000, 1'b0);
        convert(14'd4095,  1'b1, 16'h4095, 1'b0);
        drain();

        // start held high with bin stepping: only idle edges accept.
        n0 = n_done;
        for (int i = 0; i < 60; i++) begin
            bus.start = 1'b1;
            bus.bin   = 14'(1200 + i * 7);
            @(negedge clk);
        end
        bus.start = 1'b0;
        drain();
        check("held_start_accepts", 32'(n_done - n0), 32'(4));

        // Sweep segments against the arithmetic reference.
        for (int v = 0; v < 200; v++)        convert(14'(v), 1'b0, 16'h0, 1'b0);
        for (int v = 990; v <= 1010; v++)    convert(14'(v), 1'b0, 16'h0, 1'b0);
        for (int v = 9990; v <= 10010; v++)  convert(14'(v), 1'b0, 16'h0, 1'b0);
        for (int v = 0; v < 16384; v += 131) convert(14'(v), 1'b0, 16'h0, 1'b0);
        drain();

        // Reset in the middle of a conversion.
        convert(14'd7777, 1'b1, 16'h7777, 1'b0);
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'(0));
        check("midrst_done", 32'(bus.done), 32'(0));
        check("midrst_bcd", 32'(bus.bcd), 32'(0));
        check("midrst_ovf", 32'(bus.overflow), 32'(0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n0 = n_done;
        repeat (20) @(negedge clk);
        check("no_stale_done", 32'(n_done - n0), 32'(0));
        convert(14'd42, 1'b1, 16'h0042, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
